regfile_mp: RTL and testbench

Parametrised multi-port general-purpose register file with per-register busy scoreboard, the next-generation GPR file for the dual-issue pipeline. Provides NREAD combinational read ports, NWRITE clocked write ports with fixed priority, hardwired-zero register 0, and a busy bit per register that issue sets and writeback clears. Sits between decode/issue (reads, claims) and writeback (writes).

---
 rtl/regfile_mp_pkg.sv | 21 ++
 rtl/regfile_wsel.sv | 28 ++
 rtl/regfile_mp.sv | 139 +++++++++++++
 tb/tb_regfile_mp.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared types and defaults for the multi-port GPR file (regfile_mp).
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
package regfile_mp_pkg;

  localparam int unsigned DEF_WIDTH  = 32;
  localparam int unsigned DEF_NREGS  = 32;
  localparam int unsigned DEF_NREAD  = 4;
  localparam int unsigned DEF_NWRITE = 2;
  localparam int unsigned DEF_AW     = $clog2(DEF_NREGS);

  typedef logic [DEF_AW-1:0]    creg_addr_t;
  typedef logic [DEF_WIDTH-1:0] word_t;

  // Register 0 is architecturally zero: never stored, never busy.
  localparam creg_addr_t ZERO_REG = '0;

  function automatic logic is_zero_reg(input creg_addr_t addr);
    return addr == ZERO_REG;
  endfunction

endpackage

// File: rtl/regfile_wsel.sv
// Fixed-priority write selector: for one target address, picks the
// highest-index enabled write port hitting it and forwards that port's data.
module regfile_wsel #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NWRITE = 2,
  parameter int unsigned AW     = 5
) (
  input  logic [NWRITE-1:0]            we_i,
  input  logic [NWRITE-1:0][AW-1:0]    wa_i,
  input  logic [NWRITE-1:0][WIDTH-1:0] wd_i,
  input  logic [AW-1:0]                addr_i,
  output logic                         hit_o,
  output logic [WIDTH-1:0]             data_o
);

  // Later ports overwrite earlier matches, so the highest index wins.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    for (int j = 0; j < int'(NWRITE); j++) begin
      if (we_i[j] && (wa_i[j] == addr_i)) begin
        hit_o  = 1'b1;
        data_o = wd_i[j];
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port GPR file with hardwired-zero r0 and per-register busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writes onto the read ports.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter  int unsigned WIDTH  = DEF_WIDTH,
  parameter  int unsigned NREGS  = DEF_NREGS,
  parameter  int unsigned NREAD  = DEF_NREAD,
  parameter  int unsigned NWRITE = DEF_NWRITE,
  localparam int unsigned AW     = $clog2(NREGS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NREAD-1:0][AW-1:0]     ra,
  output logic [NREAD-1:0][WIDTH-1:0]  rd,
  output logic [NREAD-1:0]             rbusy,
  input  logic [NWRITE-1:0]            we,
  input  logic [NWRITE-1:0][AW-1:0]    wa,
  input  logic [NWRITE-1:0][WIDTH-1:0] wd,
  input  logic                         claim_valid,
  input  logic [AW-1:0]                claim_addr,
  output logic [AW:0]                  busy_count
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] wdat   [NREGS];
  logic [NREGS-1:0] whit;
  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]      count_q, count_d;

  // One priority selector per architectural register; r0 has none and never loads.
  for (genvar r = 0; r < int'(NREGS); r++) begin : g_reg
    if (r == 0) begin : g_zero
      assign whit[r] = 1'b0;
      assign wdat[r] = '0;
    end else begin : g_sel
      regfile_wsel #(
        .WIDTH  (WIDTH),
        .NWRITE (NWRITE),
        .AW     (AW)
      ) u_wsel (
        .we_i   (we),
        .wa_i   (wa),
        .wd_i   (wd),
        .addr_i (AW'(r)),
        .hit_o  (whit[r]),
        .data_o (wdat[r])
      );
    end

    always_ff @(posedge clk) begin
      if (reset || (r == 0)) begin
        regs_q[r] <= '0;
      end else if (whit[r]) begin
        regs_q[r] <= wdat[r];
      end
    end
  end

  // A claim is applied after the write clear so a new producer keeps the register busy.
  always_comb begin
    busy_d = busy_q & ~whit;
    if (claim_valid && (claim_addr != ZERO_ADDR)) begin
      busy_d[claim_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
    count_d   = '0;
    for (int r = 0; r < int'(NREGS); r++) begin
      count_d = count_d + {{AW{1'b0}}, busy_d[r]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign busy_count = count_q;

`ifdef REGFILE_BYPASS_EN
  logic [NREAD-1:0]            bhit;
  logic [WIDTH-1:0]            bdat [NREAD];

  // Read-side selectors reuse the write priority so forwarded data matches what gets stored.
  for (genvar p = 0; p < int'(NREAD); p++) begin : g_byp
    regfile_wsel #(
      .WIDTH  (WIDTH),
      .NWRITE (NWRITE),
      .AW     (AW)
    ) u_bsel (
      .we_i   (we),
      .wa_i   (wa),
      .wd_i   (wd),
      .addr_i (ra[p]),
      .hit_o  (bhit[p]),
      .data_o (bdat[p])
    );
  end

  always_comb begin
    rd    = '0;
    rbusy = '0;
    for (int p = 0; p < int'(NREAD); p++) begin
      if (ra[p] == ZERO_ADDR) begin
        rd[p]    = '0;
        rbusy[p] = 1'b0;
      end else if (bhit[p]) begin
        rd[p]    = bdat[p];
        rbusy[p] = claim_valid && (claim_addr == ra[p]);
      end else begin
        rd[p]    = regs_q[ra[p]];
        rbusy[p] = busy_q[ra[p]];
      end
    end
  end
`else
  always_comb begin
    rd    = '0;
    rbusy = '0;
    for (int p = 0; p < int'(NREAD); p++) begin
      if (ra[p] == ZERO_ADDR) begin
        rd[p]    = '0;
        rbusy[p] = 1'b0;
      end else begin
        rd[p]    = regs_q[ra[p]];
        rbusy[p] = busy_q[ra[p]];
      end
    end
  end
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios, then random traffic
// compared against an array/scoreboard model of the register file rules.
module tb_regfile_mp;

  localparam int WIDTH  = 32;
  localparam int NREGS  = 32;
  localparam int NREAD  = 4;
  localparam int NWRITE = 2;
  localparam int AW     = 5;

  logic                         clk = 1'b0;
  logic                         reset;
  logic [NREAD-1:0][AW-1:0]     ra;
  logic [NREAD-1:0][WIDTH-1:0]  rd;
  logic [NREAD-1:0]             rbusy;
  logic [NWRITE-1:0]            we;
  logic [NWRITE-1:0][AW-1:0]    wa;
  logic [NWRITE-1:0][WIDTH-1:0] wd;
  logic                         claimValid;
  logic [AW-1:0]                claimAddr;
  logic [AW:0]                  busyCount;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] mem [NREGS];
  bit               bsy [NREGS];
  bit               modelValid = 1'b0;

  regfile_mp #(
    .WIDTH  (WIDTH),
    .NREGS  (NREGS),
    .NREAD  (NREAD),
    .NWRITE (NWRITE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ra          (ra),
    .rd          (rd),
    .rbusy       (rbusy),
    .we          (we),
    .wa          (wa),
    .wd          (wd),
    .claim_valid (claimValid),
    .claim_addr  (claimAddr),
    .busy_count  (busyCount)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Expected read value: stored word, or this cycle's winning write when forwarding.
  function automatic logic [WIDTH-1:0] expRd(input logic [AW-1:0] a);
    logic [WIDTH-1:0] v;
    if (a == 0) return '0;
    v = mem[a];
`ifdef REGFILE_BYPASS_EN
    for (int j = 0; j < NWRITE; j++) begin
      if (we[j] && wa[j] == a) v = wd[j];
    end
`endif
    return v;
  endfunction

  function automatic logic expBusy(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    for (int j = 0; j < NWRITE; j++) begin
      if (we[j] && wa[j] == a) return claimValid && (claimAddr == a);
    end
`endif
    return bsy[a];
  endfunction

  function automatic int expCount();
    int n = 0;
    for (int r = 0; r < NREGS; r++) n += int'(bsy[r]);
    return n;
  endfunction

  // Wait for the quiet half of the cycle and compare every read port with the model.
  task automatic applyStimulus();
    @(negedge clk);
    if (modelValid) begin
      for (int p = 0; p < NREAD; p++) begin
        checkOutput($sformatf("rd p%0d r%0d", p, ra[p]), 64'(rd[p]), 64'(expRd(ra[p])));
        checkOutput($sformatf("rbusy p%0d r%0d", p, ra[p]), 64'(rbusy[p]), 64'(expBusy(ra[p])));
      end
      checkOutput("busy_count", 64'(busyCount), 64'(expCount()));
    end
  endtask

  // Advance one edge and apply the architectural rules to the model.
  task automatic clockEdge();
    @(posedge clk);
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        mem[r] = '0;
        bsy[r] = 1'b0;
      end
      modelValid = 1'b1;
    end else begin
      for (int j = 0; j < NWRITE; j++) begin
        if (we[j] && wa[j] != 0) begin
          mem[wa[j]] = wd[j];
          bsy[wa[j]] = 1'b0;
        end
      end
      if (claimValid && claimAddr != 0) bsy[claimAddr] = 1'b1;
    end
    #1;
  endtask

  task automatic setIdle();
    reset      = 1'b0;
    we         = '0;
    wa         = '0;
    wd         = '0;
    claimValid = 1'b0;
    claimAddr  = '0;
  endtask

  initial begin
    setIdle();
    ra = '0;

    // Reset while writing r5 on both ports and claiming it.
    reset      = 1'b1;
    we         = 2'b11;
    wa[0]      = 5'd5;
    wa[1]      = 5'd5;
    wd[0]      = 32'hDEAD_0001;
    wd[1]      = 32'hDEAD_0002;
    claimValid = 1'b1;
    claimAddr  = 5'd5;
    applyStimulus(); clockEdge();
    applyStimulus(); clockEdge();
    setIdle();
    ra[0] = 5'd5; ra[1] = 5'd0; ra[2] = 5'd1; ra[3] = 5'd31;
    applyStimulus();
    checkOutput("reset r5 rd", 64'(rd[0]), 64'h0);
    checkOutput("reset rbusy", 64'(rbusy), 64'h0);
    checkOutput("reset busy_count", 64'(busyCount), 64'h0);
    clockEdge();

    // Both ports write r3: port 1 wins.
    we = 2'b11; wa[0] = 5'd3; wa[1] = 5'd3; wd[0] = 32'h11; wd[1] = 32'h22;
    ra[0] = 5'd6;
    applyStimulus(); clockEdge();
    setIdle();
    ra[0] = 5'd3;
    applyStimulus();
    checkOutput("r3 port priority", 64'(rd[0]), 64'h22);
    clockEdge();

    // Writes to r0 are ignored.
    we = 2'b11; wa[0] = 5'd0; wa[1] = 5'd0; wd[0] = 32'hFFFF_FFFF; wd[1] = 32'hFFFF_FFFF;
    applyStimulus(); clockEdge();
    setIdle();
    ra[0] = 5'd0;
    applyStimulus();
    checkOutput("r0 hardwired", 64'(rd[0]), 64'h0);
    clockEdge();

    // Claim r7, then write it back.
    claimValid = 1'b1; claimAddr = 5'd7; ra[0] = 5'd7;
    applyStimulus(); clockEdge();
    setIdle();
    we[0] = 1'b1; wa[0] = 5'd7; wd[0] = 32'hABCD; ra[0] = 5'd7;
    applyStimulus();
`ifdef REGFILE_BYPASS_EN
    checkOutput("r7 busy during wb", 64'(rbusy[0]), 64'h0);
`else
    checkOutput("r7 busy during wb", 64'(rbusy[0]), 64'h1);
`endif
    checkOutput("count after claim r7", 64'(busyCount), 64'h1);
    clockEdge();
    setIdle();
    ra[0] = 5'd7;
    applyStimulus();
    checkOutput("r7 busy after wb", 64'(rbusy[0]), 64'h0);
    checkOutput("r7 data after wb", 64'(rd[0]), 64'hABCD);
    checkOutput("count after wb r7", 64'(busyCount), 64'h0);
    clockEdge();

    // Claim and write r9 in the same cycle: claim wins, data still lands.
    claimValid = 1'b1; claimAddr = 5'd9;
    we[1] = 1'b1; wa[1] = 5'd9; wd[1] = 32'h5;
    applyStimulus(); clockEdge();
    setIdle();
    ra[0] = 5'd9;
    applyStimulus();
    checkOutput("r9 claim wins busy", 64'(rbusy[0]), 64'h1);
    checkOutput("r9 data written", 64'(rd[0]), 64'h5);
    checkOutput("count r9", 64'(busyCount), 64'h1);
    clockEdge();

    // Same-cycle read of a register being written.
    we[0] = 1'b1; wa[0] = 5'd4; wd[0] = 32'h1234; ra[0] = 5'd4;
    applyStimulus();
`ifdef REGFILE_BYPASS_EN
    checkOutput("r4 same-cycle read", 64'(rd[0]), 64'h1234);
`else
    checkOutput("r4 same-cycle read", 64'(rd[0]), 64'h0);
`endif
    clockEdge();

    // Claims over three cycles, reset lands on the third.
    setIdle();
    claimValid = 1'b1; claimAddr = 5'd2;
    applyStimulus(); clockEdge();
    claimAddr = 5'd3;
    applyStimulus(); clockEdge();
    claimAddr = 5'd4; reset = 1'b1;
    applyStimulus(); clockEdge();
    setIdle();
    ra[0] = 5'd2; ra[1] = 5'd3; ra[2] = 5'd4; ra[3] = 5'd9;
    applyStimulus();
    checkOutput("count after mid reset", 64'(busyCount), 64'h0);
    checkOutput("rbusy after mid reset", 64'(rbusy), 64'h0);
    clockEdge();

    // Random traffic biased toward a few registers to provoke collisions.
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      for (int j = 0; j < NWRITE; j++) begin
        we[j] = 1'($urandom_range(0, 1));
        wa[j] = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
        wd[j] = $urandom;
      end
      claimValid = ($urandom_range(0, 2) == 0);
      claimAddr  = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      for (int p = 0; p < NREAD; p++) begin
        case ($urandom_range(0, 3))
          0:       ra[p] = wa[0];
          1:       ra[p] = wa[1];
          2:       ra[p] = claimAddr;
          default: ra[p] = AW'($urandom);
        endcase
      end
      applyStimulus();
      clockEdge();
    end

    setIdle();
    for (int k = 0; k < 8; k++) begin
      for (int p = 0; p < NREAD; p++) ra[p] = AW'(k * NREAD + p);
      applyStimulus();
      clockEdge();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
